// File: rtl/ib_fetch_ctrl_pkg.sv
// Shared widths and state type for the fetch scheduler, instruction buffer and fetch stage.
package ib_fetch_ctrl_pkg;

    localparam int unsigned IF_WIDTH     = 2;
    localparam int unsigned ID_WIDTH     = 2;
    localparam int unsigned BUFFER_SIZE  = 16;
    localparam int unsigned MAX_INFLIGHT = 4;

    localparam int unsigned CREDIT_W   = $clog2(BUFFER_SIZE) + 1;
    localparam int unsigned INFLIGHT_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int unsigned RESP_NUM_W = $clog2(IF_WIDTH) + 1;
    localparam int unsigned ACCEPT_W   = $clog2(ID_WIDTH) + 1;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ib_fetch_state_t;

endpackage

// File: rtl/ib_credit_counter.sv
// Saturating up/down counter with synchronous load; flags an attempt to exceed MAX_VAL.
module ib_credit_counter #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned MAX_VAL   = 16,
    parameter int unsigned RESET_VAL = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] inc,
    input  logic [WIDTH-1:0] dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow_c
);

    // Two guard bits: the top bit is set only when the net result went negative.
    localparam int unsigned EW = WIDTH + 2;

    logic [EW-1:0]    sum_c;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        sum_c      = EW'(count) + EW'(inc) - EW'(dec);
        overflow_c = 1'b0;
        count_d    = count;
        if (load) begin
            count_d = load_val;
        end else if (sum_c[EW-1]) begin
            count_d = '0;
        end else if (sum_c > EW'(MAX_VAL)) begin
            count_d    = WIDTH'(MAX_VAL);
            overflow_c = 1'b1;
        end else begin
            count_d = sum_c[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= WIDTH'(RESET_VAL);
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/ib_fetch_ctrl.sv
// Credit-based fetch scheduler: issues fetch groups only when a full group has a buffer slot,
// and after a backend flush discards all in-flight responses before fetching again.
module ib_fetch_ctrl
    import ib_fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fetch_req_o,
    input  logic                  fetch_ready_i,
    input  logic                  fetch_resp_valid_i,
    input  logic [RESP_NUM_W-1:0] fetch_resp_num_i,
    output logic                  ib_write_en_o,
    input  logic [ACCEPT_W-1:0]   backend_accept_num_i,
    input  logic                  backend_flush_i,
    output logic [CREDIT_W-1:0]   credit_o,
    output logic [INFLIGHT_W-1:0] inflight_o,
    output logic                  draining_o,
    output logic                  error_o
);

    localparam logic [0:0] ST_RUN   = 1'(RUN);
    localparam logic [0:0] ST_DRAIN = 1'(DRAIN);

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic                  issue_c;
    logic                  resp_hit_c;
    logic                  resp_orphan_c;
    logic [CREDIT_W-1:0]   resp_unused_c;
    logic [INFLIGHT_W-1:0] inflight_after_c;
    logic                  credit_load_c;
    logic [CREDIT_W-1:0]   credit_inc_c;
    logic [CREDIT_W-1:0]   credit_dec_c;
    logic [INFLIGHT_W-1:0] inflight_inc_c;
    logic [INFLIGHT_W-1:0] inflight_dec_c;
    logic                  credit_ovf_c;
    logic                  inflight_ovf_c;

    // A response only counts against a real outstanding group; otherwise it is an error.
    assign resp_hit_c       = fetch_resp_valid_i && (inflight_o != '0);
    assign resp_orphan_c    = fetch_resp_valid_i && (inflight_o == '0);
    assign inflight_after_c = inflight_o - INFLIGHT_W'(resp_hit_c);
    assign resp_unused_c    = (fetch_resp_num_i <= RESP_NUM_W'(IF_WIDTH))
                            ? CREDIT_W'(IF_WIDTH) - CREDIT_W'(fetch_resp_num_i) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, request gating and counter deltas.
    always_comb begin
        state_d        = state_q;
        fetch_req_o    = 1'b0;
        ib_write_en_o  = 1'b0;
        issue_c        = 1'b0;
        credit_load_c  = 1'b0;
        credit_inc_c   = '0;
        credit_dec_c   = '0;
        inflight_inc_c = '0;
        inflight_dec_c = INFLIGHT_W'(resp_hit_c);
        if (backend_flush_i) begin
            credit_load_c = 1'b1;
            state_d       = (inflight_after_c != '0) ? ST_DRAIN : ST_RUN;
        end else if (state_q == ST_RUN) begin
            fetch_req_o    = rst_n && (credit_o >= CREDIT_W'(IF_WIDTH))
                           && (inflight_o < INFLIGHT_W'(MAX_INFLIGHT));
            issue_c        = fetch_req_o && fetch_ready_i;
            ib_write_en_o  = resp_hit_c;
            credit_inc_c   = CREDIT_W'(backend_accept_num_i)
                           + (resp_hit_c ? resp_unused_c : CREDIT_W'(0));
            credit_dec_c   = issue_c ? CREDIT_W'(IF_WIDTH) : CREDIT_W'(0);
            inflight_inc_c = INFLIGHT_W'(issue_c);
        end else begin
            if (inflight_after_c == '0) begin
                state_d = ST_RUN;
            end
        end
    end

    ib_credit_counter #(
        .WIDTH     (CREDIT_W),
        .MAX_VAL   (BUFFER_SIZE),
        .RESET_VAL (BUFFER_SIZE)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (credit_load_c),
        .load_val   (CREDIT_W'(BUFFER_SIZE)),
        .inc        (credit_inc_c),
        .dec        (credit_dec_c),
        .count      (credit_o),
        .overflow_c (credit_ovf_c)
    );

    ib_credit_counter #(
        .WIDTH     (INFLIGHT_W),
        .MAX_VAL   (MAX_INFLIGHT),
        .RESET_VAL (0)
    ) u_inflight (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .load_val   ('0),
        .inc        (inflight_inc_c),
        .dec        (inflight_dec_c),
        .count      (inflight_o),
        .overflow_c (inflight_ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_o <= 1'b0;
        end else begin
            error_o <= error_o | resp_orphan_c | credit_ovf_c | inflight_ovf_c;
        end
    end

    assign draining_o = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Self-checking bench for ib_fetch_ctrl: directed vector table, reset/overflow sequence, random vs. model.
module tb_ib_fetch_ctrl;
    import ib_fetch_ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  fetch_req;
    logic                  fetch_ready;
    logic                  resp_valid;
    logic [RESP_NUM_W-1:0] resp_num;
    logic                  ib_write_en;
    logic [ACCEPT_W-1:0]   accept_num;
    logic                  flush;
    logic [CREDIT_W-1:0]   credit;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  draining;
    logic                  error;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ib_fetch_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .fetch_req_o          (fetch_req),
        .fetch_ready_i        (fetch_ready),
        .fetch_resp_valid_i   (resp_valid),
        .fetch_resp_num_i     (resp_num),
        .ib_write_en_o        (ib_write_en),
        .backend_accept_num_i (accept_num),
        .backend_flush_i      (flush),
        .credit_o             (credit),
        .inflight_o           (inflight),
        .draining_o           (draining),
        .error_o              (error)
    );

    typedef struct {
        logic rdy;
        logic rv;
        int   num;
        int   acc;
        logic fl;
        logic req;
        logic wen;
        int   cr;
        int   inf;
        logic dr;
        logic err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, rv, input int num, acc, input logic fl,
                       input logic req, wen, input int cr, inf, input logic dr, err);
        vq.push_back('{rdy, rv, num, acc, fl, req, wen, cr, inf, dr, err});
    endtask

    task automatic drive(input logic rdy, rv, input int num, acc, input logic fl);
        fetch_ready = rdy;
        resp_valid  = rv;
        resp_num    = RESP_NUM_W'(num);
        accept_num  = ACCEPT_W'(acc);
        flush       = fl;
    endtask

    task automatic chk_state(input string tag, input int cr, inf, input logic dr, err);
        chk({tag, " credit"},   int'(credit),   cr);
        chk({tag, " inflight"}, int'(inflight), inf);
        chk({tag, " draining"}, int'(draining), int'(dr));
        chk({tag, " error"},    int'(error),    int'(err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1 chk("req during reset", int'(fetch_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state("post-reset", 16, 0, 0, 0);
        chk("post-reset wen", int'(ib_write_en), 0);
    endtask

    // Reference model state: integer counts derived directly from the operating rules.
    int   m_cr, m_inf;
    logic m_dr, m_err;

    task automatic model_step(input logic rdy, rv, input int num, acc, input logic fl,
                              output logic e_req, output logic e_wen);
        logic hit;
        logic issue;
        int   t;
        e_req = !m_dr && !fl && m_cr >= IF_WIDTH && m_inf < MAX_INFLIGHT;
        hit   = rv && m_inf > 0;
        e_wen = hit && !m_dr && !fl;
        if (rv && m_inf == 0) m_err = 1'b1;
        if (fl) begin
            m_cr  = BUFFER_SIZE;
            m_inf = m_inf - (hit ? 1 : 0);
            m_dr  = (m_inf != 0);
        end else if (m_dr) begin
            m_inf = m_inf - (hit ? 1 : 0);
            if (m_inf == 0) m_dr = 1'b0;
        end else begin
            issue = e_req && rdy;
            t = m_cr + acc + (hit ? IF_WIDTH - num : 0) - (issue ? IF_WIDTH : 0);
            if (t > BUFFER_SIZE) begin
                m_err = 1'b1;
                t     = BUFFER_SIZE;
            end
            m_cr  = t;
            m_inf = m_inf + (issue ? 1 : 0) - (hit ? 1 : 0);
        end
    endtask

    initial begin
        // rdy rv num acc fl | req wen credit inflight drain err (after the edge)
        add(1,0,0,0,0, 1,0, 14,1,0,0);
        add(1,0,0,0,0, 1,0, 12,2,0,0);
        add(1,0,0,0,0, 1,0, 10,3,0,0);
        add(1,0,0,0,0, 1,0,  8,4,0,0);
        add(1,0,0,0,0, 0,0,  8,4,0,0);
        add(1,0,0,0,0, 0,0,  8,4,0,0);
        add(0,1,1,0,0, 0,1,  9,3,0,0);
        add(1,1,2,0,0, 1,1,  7,3,0,0);
        add(0,0,0,2,0, 1,0,  9,3,0,0);
        add(1,1,2,2,1, 0,0, 16,2,1,0);
        add(1,1,1,2,0, 0,0, 16,1,1,0);
        add(1,1,2,0,0, 0,0, 16,0,0,0);
        add(0,0,0,0,0, 1,0, 16,0,0,0);
        add(1,0,0,2,1, 0,0, 16,0,0,0);
        add(1,0,0,0,0, 1,0, 14,1,0,0);
        for (int k = 0; k < 7; k++) add(1,1,2,0,0, 1,1, 12 - 2*k,1,0,0);
        add(1,0,0,0,0, 0,0,  0,1,0,0);
        add(1,0,0,2,0, 0,0,  2,1,0,0);
        add(1,0,0,0,0, 1,0,  0,2,0,0);
        add(0,1,2,0,0, 0,1,  0,1,0,0);
        add(0,1,2,0,0, 0,1,  0,0,0,0);
        add(0,1,2,0,0, 0,0,  0,0,0,1);
        add(0,0,0,2,0, 0,0,  2,0,0,1);
        add(0,0,0,0,0, 1,0,  2,0,0,1);

        do_reset();
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rdy, vq[i].rv, vq[i].num, vq[i].acc, vq[i].fl);
            #1;
            chk($sformatf("vec%0d req", i), int'(fetch_req),   int'(vq[i].req));
            chk($sformatf("vec%0d wen", i), int'(ib_write_en), int'(vq[i].wen));
            @(posedge clk);
            #1 chk_state($sformatf("vec%0d", i), vq[i].cr, vq[i].inf, vq[i].dr, vq[i].err);
        end

        // Credit overflow from a pop at full credit, then async reset in the middle of DRAIN.
        do_reset();
        @(negedge clk); drive(0, 0, 0, 2, 0);
        @(posedge clk); #1 chk_state("ovf", 16, 0, 0, 1);
        @(negedge clk); drive(1, 0, 0, 0, 0);
        @(negedge clk); drive(1, 0, 0, 0, 0);
        @(negedge clk); drive(1, 0, 0, 0, 1);
        @(posedge clk); #1 chk_state("flush2", 16, 2, 1, 1);
        @(negedge clk); drive(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("midrain-reset", 16, 0, 0, 0);
        chk("midrain-reset req", int'(fetch_req), 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("req after release", int'(fetch_req), 1);

        // Randomized legal traffic against the reference model.
        do_reset();
        m_cr = BUFFER_SIZE; m_inf = 0; m_dr = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic rdy, rv, fl, e_req, e_wen;
            int   num, acc, occ;
            @(negedge clk);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = (m_inf > 0) && ($urandom_range(0, 1) == 1);
            num = int'($urandom_range(0, IF_WIDTH));
            occ = m_dr ? 0 : BUFFER_SIZE - m_cr - IF_WIDTH * m_inf;
            acc = int'($urandom_range(0, ID_WIDTH));
            if (acc > occ) acc = (occ < 0) ? 0 : occ;
            fl  = ($urandom_range(0, 15) == 0);
            drive(rdy, rv, num, acc, fl);
            #1;
            chk_state($sformatf("rnd%0d", c), m_cr, m_inf, m_dr, m_err);
            model_step(rdy, rv, num, acc, fl, e_req, e_wen);
            chk($sformatf("rnd%0d req", c), int'(fetch_req),   int'(e_req));
            chk($sformatf("rnd%0d wen", c), int'(ib_write_en), int'(e_wen));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1 chk_state("rnd-final", m_cr, m_inf, m_dr, m_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ib_fetch_ctrl.md
# ib_fetch_ctrl

Credit-based fetch scheduler and flush sequencer sitting between the fetch unit and the instruction buffer. It tracks free buffer entries as credits, counts fetch groups in flight, and issues fetch requests only when a full group is guaranteed a slot. On a backend flush it discards every in-flight fetch response before allowing new fetches to be issued.

## Interface
- IF_WIDTH, 2, instructions per fetch group
- ID_WIDTH, 2, max instructions popped by backend per cycle
- BUFFER_SIZE, 16, instruction buffer entries (power of two)
- MAX_INFLIGHT, 4, max outstanding fetch groups
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_req_o  out  1  request one fetch group
- fetch_ready_i  in  1  fetch unit accepts request (handshake = req & ready)
- fetch_resp_valid_i  in  1  a fetch group returns this cycle
- fetch_resp_num_i  in  $clog2(IF_WIDTH)+1  valid instructions in returned group (0..IF_WIDTH)
- ib_write_en_o  out  1  qualifies returned group for buffer write; 0 means discard
- backend_accept_num_i  in  $clog2(ID_WIDTH)+1  instructions popped from buffer this cycle
- backend_flush_i  in  1  flush buffer and redirect
- credit_o  out  $clog2(BUFFER_SIZE)+1  current free-credit count
- inflight_o  out  $clog2(MAX_INFLIGHT)+1  outstanding fetch groups
- draining_o  out  1  state is DRAIN
- error_o  out  1  sticky: response with zero in-flight, or credit overflow

## Operation
- States: RUN, DRAIN. Reset state RUN.
- fetch_req_o = (state==RUN) & !backend_flush_i & (credit >= IF_WIDTH) & (inflight < MAX_INFLIGHT).
- Issue (req & ready): credit -= IF_WIDTH, inflight += 1.
- Response in RUN without flush: ib_write_en_o=1; credit += IF_WIDTH - fetch_resp_num_i (return unused reserved slots); inflight -= 1.
- Pop: credit += backend_accept_num_i (RUN, no flush).
- All three updates combine in one cycle as a single net add/sub; credit never exceeds BUFFER_SIZE. Exceeding it sets error_o and saturates at BUFFER_SIZE.
- Flush (backend_flush_i=1, any state): credit <= BUFFER_SIZE; the same cycle's pop and any response are ignored (ib_write_en_o=0). inflight <= inflight minus the response arriving that cycle. Next state DRAIN if the resulting inflight != 0, else RUN.
- DRAIN: fetch_req_o=0; every response has ib_write_en_o=0 and inflight -= 1, with no credit change. When inflight reaches 0 (the cycle the last response arrives), the next state is RUN. A new flush in DRAIN stays in DRAIN and re-applies the flush rules.
- Response while inflight==0: ignored, error_o set.
- error_o clears only on reset.

## Timing
- Reset values: fetch_req_o=0 while rst_n low; after release, credit_o=BUFFER_SIZE, inflight_o=0, draining_o=0, error_o=0, ib_write_en_o=0. fetch_req_o may assert in the first cycle after release.
- fetch_req_o and ib_write_en_o are combinational from state, counters and same-cycle inputs (flush, resp_valid). No registered delay.
- Counter updates are visible the cycle after the event. Credits returned by a pop allow a request in the next cycle.
- Max throughput: one group issued per cycle while credit and inflight allow.
- Flush-to-first-request latency: 1 cycle if inflight==0, otherwise 1 cycle after the last discarded response.
- Reset mid-DRAIN: state returns to RUN and counters reinitialise immediately (async).

## Structure
- Shared package: fetch-group credit width, inflight width, and the state enum (ib_fetch_state_t {RUN, DRAIN}) so the instruction buffer and fetch stage share the same widths.
- One sub-module is natural: ib_credit_counter, a saturating up/down counter with overflow flag, instanced for credit. The inflight counter reuses the same sub-module.
- Remaining logic (FSM, request gating) stays in the top module, about 150–250 lines.

## Test plan
- Reset, ready=1, no pops, responses never return: exactly 4 requests are issued (MAX_INFLIGHT); credit_o=8 and inflight_o=4; fetch_req_o then stays 0.
- Responses return with num=2 and no pops until credit=0: requests total 8 groups, then fetch_req_o=0. Popping 2 restores credit to 2, and fetch_req_o=1 on the next cycle.
- Response with num=1: credit_o rises by 1 the next cycle. The buffer write is qualified with ib_write_en_o=1.
- Flush with inflight=3 and one response in the same cycle: credit_o=16, inflight_o=2, draining_o=1. The next 2 responses get ib_write_en_o=0. fetch_req_o=1 the cycle after the last one.
- Flush while inflight=0, coincident with req&ready and a pop: no issue is counted, credit_o=16, state stays RUN, and a request is made the following cycle.
- Response with inflight=0: ignored, error_o=1 and sticky until rst_n is asserted low. Asserting rst_n low mid-DRAIN restores all reset values.
